// File: rtl/rect_draw_if.sv
// ---------------------------------------------------------------------------
// rect_draw_if -- command / pixel bundle for rect_draw_engine.
//   master : the command issuer and pixel sink (drives start, origin, extent,
//            mode, colour and pix_ready; observes the pixel stream/status).
//   slave  : the drawing engine.
// Signals:
//   start, x0, y0, w, h, mode, color_in : draw command
//   pix_ready                           : sink accepts the current pixel
//   plot, x, y, color                   : pixel stream
//   busy, done, pix_count               : command status
// ---------------------------------------------------------------------------
interface rect_draw_if #(
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int COLOR_W = 3,
    parameter int DIM_W   = 7
);
    logic                 start;
    logic [X_W-1:0]       x0;
    logic [Y_W-1:0]       y0;
    logic [DIM_W-1:0]     w;
    logic [DIM_W-1:0]     h;
    logic [1:0]           mode;
    logic [COLOR_W-1:0]   color_in;
    logic                 pix_ready;
    logic                 plot;
    logic [X_W-1:0]       x;
    logic [Y_W-1:0]       y;
    logic [COLOR_W-1:0]   color;
    logic                 busy;
    logic                 done;
    logic [2*DIM_W-1:0]   pix_count;

    modport master (
        output start, x0, y0, w, h, mode, color_in, pix_ready,
        input  plot, x, y, color, busy, done, pix_count
    );

    modport slave (
        input  start, x0, y0, w, h, mode, color_in, pix_ready,
        output plot, x, y, color, busy, done, pix_count
    );
endinterface

// File: rtl/rect_draw_engine.sv
// ---------------------------------------------------------------------------
// rect_draw_engine -- scans a rectangle (fill / outline) or a diagonal line
// and emits one pixel position per cycle, honouring sink back-pressure.
// Ports:
//   clk    : rising-edge clock
//   resetn : asynchronous active-low reset
//   bus    : rect_draw_if.slave (command in, pixel stream and status out)
// Configuration macro:
//   RECT_DRAW_DIAG_EN -- when defined, modes 10/11 draw diagonals; otherwise
//   they complete as zero-pixel commands and no diagonal logic exists.
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module rect_draw_engine #(
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int COLOR_W = 3,
    parameter int DIM_W   = 7
) (
    input  logic       clk,
    input  logic       resetn,
    rect_draw_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    typedef struct packed {
        logic           plot;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } pix_t;

    localparam logic [DIM_W-1:0]   DIM_ZERO = {DIM_W{1'b0}};
    localparam logic [DIM_W-1:0]   DIM_ONE  = {{(DIM_W-1){1'b0}}, 1'b1};
    localparam logic [2*DIM_W-1:0] CNT_ONE  = {{(2*DIM_W-1){1'b0}}, 1'b1};

    // Pixel (and whether it is plotted) at scan position (col,row).
    function automatic pix_t pix_at(input logic [1:0] m, input logic [X_W-1:0] ox,
                                    input logic [Y_W-1:0] oy, input logic [DIM_W-1:0] pw,
                                    input logic [DIM_W-1:0] ph, input logic [DIM_W-1:0] col,
                                    input logic [DIM_W-1:0] row);
        pix_t p;
        p.plot = 1'b0;
        p.x    = ox + X_W'(col);
        p.y    = oy + Y_W'(row);
        case (m)
            2'b00: p.plot = 1'b1;
            2'b01: p.plot = (col == DIM_ZERO) || (col == pw - DIM_ONE) ||
                            (row == DIM_ZERO) || (row == ph - DIM_ONE);
`ifdef RECT_DRAW_DIAG_EN
            2'b10: begin
                p.plot = 1'b1;
                p.y    = oy + Y_W'(col);
            end
            2'b11: begin
                p.plot = 1'b1;
                p.x    = ox + X_W'(pw - DIM_ONE - col);
                p.y    = oy + Y_W'(col);
            end
`endif
            default: p.plot = 1'b0;
        endcase
        return p;
    endfunction

    // A command with no pixels still spends one RUN cycle.
    function automatic logic is_empty(input logic [1:0] m, input logic [DIM_W-1:0] pw,
                                      input logic [DIM_W-1:0] ph);
`ifdef RECT_DRAW_DIAG_EN
        return (pw == DIM_ZERO) || (!m[1] && (ph == DIM_ZERO));
`else
        return (pw == DIM_ZERO) || m[1] || (ph == DIM_ZERO);
`endif
    endfunction

    state_t               state_q, state_d;
    logic [X_W-1:0]       x0_q, x0_d, x_q, x_d;
    logic [Y_W-1:0]       y0_q, y0_d, y_q, y_d;
    logic [DIM_W-1:0]     w_q, w_d, h_q, h_d, col_q, col_d, row_q, row_d;
    logic [1:0]           mode_q, mode_d;
    logic [COLOR_W-1:0]   color_q, color_d;
    logic                 plot_q, plot_d, busy_q, busy_d, done_q, done_d;
    logic [2*DIM_W-1:0]   pix_count_q, pix_count_d;
    logic                 advance_s, last_s;
    logic [DIM_W-1:0]     col_n_s, row_n_s;
    pix_t                 pix_s;

    // Scan moves on when no pixel is offered or the sink takes it.
    assign advance_s = (state_q == RUN) && (!plot_q || bus.pix_ready);
    assign last_s    = is_empty(mode_q, w_q, h_q) ||
                       ((col_q == w_q - DIM_ONE) && (mode_q[1] || (row_q == h_q - DIM_ONE)));

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x0_q <= '0; y0_q <= '0; w_q <= '0; h_q <= '0; mode_q <= 2'b00;
            col_q <= '0; row_q <= '0; x_q <= '0; y_q <= '0; color_q <= '0;
            plot_q <= 1'b0; busy_q <= 1'b0; done_q <= 1'b0; pix_count_q <= '0;
        end else begin
            x0_q <= x0_d; y0_q <= y0_d; w_q <= w_d; h_q <= h_d; mode_q <= mode_d;
            col_q <= col_d; row_q <= row_d; x_q <= x_d; y_q <= y_d; color_q <= color_d;
            plot_q <= plot_d; busy_q <= busy_d; done_q <= done_d; pix_count_q <= pix_count_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = RUN;
                else           state_d = IDLE;
            end
            RUN: begin
                if (advance_s && last_s) state_d = DONE;
                else                     state_d = RUN;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        x0_d = x0_q; y0_d = y0_q; w_d = w_q; h_d = h_q; mode_d = mode_q;
        col_d = col_q; row_d = row_q; x_d = x_q; y_d = y_q; color_d = color_q;
        plot_d = plot_q; pix_count_d = pix_count_q;
        col_n_s = col_q; row_n_s = row_q;
        pix_s = '0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    x0_d = bus.x0; y0_d = bus.y0; w_d = bus.w; h_d = bus.h;
                    mode_d = bus.mode; color_d = bus.color_in;
                    col_d = DIM_ZERO; row_d = DIM_ZERO; pix_count_d = '0;
                    pix_s  = pix_at(bus.mode, bus.x0, bus.y0, bus.w, bus.h, DIM_ZERO, DIM_ZERO);
                    plot_d = pix_s.plot && !is_empty(bus.mode, bus.w, bus.h);
                    x_d    = pix_s.x;
                    y_d    = pix_s.y;
                end else begin
                    plot_d = 1'b0;
                end
            end
            RUN: begin
                if (plot_q && bus.pix_ready) pix_count_d = pix_count_q + CNT_ONE;
                else                         pix_count_d = pix_count_q;
                if (advance_s && last_s) begin
                    plot_d = 1'b0;
                end else if (advance_s) begin
                    // Diagonals step col only; rasters wrap col into the next row.
                    if (mode_q[1]) begin
                        col_n_s = col_q + DIM_ONE;
                    end else if (col_q == w_q - DIM_ONE) begin
                        col_n_s = DIM_ZERO;
                        row_n_s = row_q + DIM_ONE;
                    end else begin
                        col_n_s = col_q + DIM_ONE;
                    end
                    col_d  = col_n_s;
                    row_d  = row_n_s;
                    pix_s  = pix_at(mode_q, x0_q, y0_q, w_q, h_q, col_n_s, row_n_s);
                    plot_d = pix_s.plot;
                    x_d    = pix_s.x;
                    y_d    = pix_s.y;
                end else begin
                    plot_d = plot_q;
                end
            end
            DONE:    plot_d = 1'b0;
            default: plot_d = 1'b0;
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    assign bus.plot      = plot_q;
    assign bus.x         = x_q;
    assign bus.y         = y_q;
    assign bus.color     = color_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pix_count = pix_count_q;
endmodule

// File: tb/tb_rect_draw_engine.sv
// ---------------------------------------------------------------------------
// tb_rect_draw_engine -- self-checking bench for rect_draw_engine.
// A reference model lists the expected accepted pixels of each command;
// the bench drives commands with various pix_ready policies and compares
// every accepted pixel, hold behaviour, counts and timing.
// ---------------------------------------------------------------------------
module tb_rect_draw_engine;
    localparam int X_W = 8, Y_W = 7, COLOR_W = 3, DIM_W = 7;
    localparam int XMOD = 1 << X_W, YMOD = 1 << Y_W;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    rect_draw_if #(.X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W), .DIM_W(DIM_W)) bus ();
    rect_draw_engine #(.X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W), .DIM_W(DIM_W))
        dut (.clk(clk), .resetn(resetn), .bus(bus));

    int n_vec = 0;
    int n_err = 0;

    typedef struct { int x; int y; } pix_t;
    pix_t exp_q[$];

    typedef struct { int m, x0, y0, w, h, col, rpol, cnt, runc, fx, fy; } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected accepted pixels in order; npos = scan cycles without stalls.
    task automatic model(input int m, input int x0, input int y0, input int w, input int h,
                         output int npos);
        pix_t p;
        exp_q.delete();
        npos = 1;
        if (m >= 2) begin
`ifdef RECT_DRAW_DIAG_EN
            if (w > 0) begin
                npos = w;
                for (int i = 0; i < w; i++) begin
                    p.x = ((m == 2) ? (x0 + i) : (x0 + w - 1 - i)) % XMOD;
                    p.y = (y0 + i) % YMOD;
                    exp_q.push_back(p);
                end
            end
`endif
        end else if (w > 0 && h > 0) begin
            npos = w * h;
            for (int r = 0; r < h; r++)
                for (int c = 0; c < w; c++)
                    if (m == 0 || c == 0 || c == w - 1 || r == 0 || r == h - 1) begin
                        p.x = (x0 + c) % XMOD;
                        p.y = (y0 + r) % YMOD;
                        exp_q.push_back(p);
                    end
        end
    endtask

    // rpol: 0 always ready, 1 random ready, 2 first pixel refused 3 cycles.
    task automatic run_cmd(input int m, input int x0, input int y0, input int w, input int h,
                           input int col, input int rpol, output int cnt, output int runc,
                           output int stalls, output int fx, output int fy);
        int npos, nexp, budget, hold_x, hold_y, stall_left;
        bit held;
        logic rdy;
        pix_t e;
        model(m, x0, y0, w, h, npos);
        nexp = exp_q.size();
        cnt = 0; runc = 0; stalls = 0; fx = -1; fy = -1; held = 0; budget = 0;
        stall_left = (rpol == 2) ? 3 : 0;
        @(negedge clk);
        bus.start = 1'b1; bus.mode = m[1:0]; bus.x0 = x0[X_W-1:0]; bus.y0 = y0[Y_W-1:0];
        bus.w = w[DIM_W-1:0]; bus.h = h[DIM_W-1:0]; bus.color_in = col[COLOR_W-1:0];
        @(negedge clk);
        bus.start = 1'b0;
        while (!bus.done && budget < 400) begin
            chk("busy_run", {31'd0, bus.busy}, 32'd1);
            chk("pix_count_run", {18'd0, bus.pix_count}, cnt);
            if (held) begin
                chk("hold_x", {24'd0, bus.x}, hold_x);
                chk("hold_y", {25'd0, bus.y}, hold_y);
                chk("hold_plot", {31'd0, bus.plot}, 32'd1);
            end
            case (rpol)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom_range(0, 9) < 7);
                default: rdy = !(bus.plot && stall_left > 0);
            endcase
            if (rpol == 2 && bus.plot && stall_left > 0) stall_left--;
            bus.pix_ready = rdy;
            held = 0;
            if (bus.plot) begin
                if (rdy) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_pixel", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pix_x", {24'd0, bus.x}, e.x);
                        chk("pix_y", {25'd0, bus.y}, e.y);
                        chk("pix_color", {29'd0, bus.color}, col);
                    end
                    if (cnt == 0) begin fx = bus.x; fy = bus.y; end
                    cnt++;
                end else begin
                    stalls++; held = 1; hold_x = bus.x; hold_y = bus.y;
                end
            end
            // Garbage start while busy must be ignored.
            bus.start = ($urandom_range(0, 3) == 0);
            bus.x0 = X_W'($urandom); bus.y0 = Y_W'($urandom);
            bus.w = DIM_W'($urandom); bus.mode = 2'($urandom);
            runc++; budget++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.pix_ready = 1'b1;
        if (budget >= 400) chk("timeout", 32'd1, 32'd0);
        chk("done_pulse", {31'd0, bus.done}, 32'd1);
        chk("busy_at_done", {31'd0, bus.busy}, 32'd0);
        chk("plot_at_done", {31'd0, bus.plot}, 32'd0);
        chk("pix_count_done", {18'd0, bus.pix_count}, nexp);
        chk("pixels_missing", exp_q.size(), 32'd0);
        chk("run_cycles", runc, npos + stalls);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, bus.done}, 32'd0);
        chk("pix_count_idle", {18'd0, bus.pix_count}, nexp);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_plot"}, {31'd0, bus.plot}, 32'd0);
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
        chk({tag, "_x"}, {24'd0, bus.x}, 32'd0);
        chk({tag, "_y"}, {25'd0, bus.y}, 32'd0);
        chk({tag, "_color"}, {29'd0, bus.color}, 32'd0);
        chk({tag, "_count"}, {18'd0, bus.pix_count}, 32'd0);
    endtask

    initial begin
        int cnt, runc, stalls, fx, fy, done_seen;
        //           m  x0   y0   w  h  col rpol cnt runc fx   fy
        tbl[0] = '{0, 10,  20,  3, 2, 5,  0,   6,  6,  10,  20};
        tbl[1] = '{1, 30,  40,  4, 3, 2,  0,   10, 12, 30,  40};
        tbl[2] = '{0, 1,   1,   2, 1, 7,  2,   2,  5,  1,   1};
        tbl[3] = '{0, 5,   5,   0, 4, 1,  0,   0,  1,  -1,  -1};
        tbl[4] = '{1, 5,   5,   3, 0, 1,  0,   0,  1,  -1,  -1};
`ifdef RECT_DRAW_DIAG_EN
        tbl[5] = '{3, 250, 0,   8, 3, 3,  0,   8,  8,  1,   0};
        tbl[6] = '{2, 100, 120, 4, 0, 6,  0,   4,  4,  100, 120};
`else
        tbl[5] = '{3, 250, 0,   8, 3, 3,  0,   0,  1,  -1,  -1};
        tbl[6] = '{2, 100, 120, 4, 0, 6,  0,   0,  1,  -1,  -1};
`endif
        tbl[7] = '{0, 255, 127, 2, 2, 1,  0,   4,  4,  255, 127};

        resetn = 1'b0;
        bus.start = 1'b0; bus.x0 = '0; bus.y0 = '0; bus.w = '0; bus.h = '0;
        bus.mode = 2'b00; bus.color_in = '0; bus.pix_ready = 1'b1;
        #1;
        chk_zero("reset");
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_cmd(tbl[i].m, tbl[i].x0, tbl[i].y0, tbl[i].w, tbl[i].h, tbl[i].col,
                    tbl[i].rpol, cnt, runc, stalls, fx, fy);
            chk("tbl_count", cnt, tbl[i].cnt);
            chk("tbl_run_cycles", runc, tbl[i].runc);
            chk("tbl_first_x", fx, tbl[i].fx);
            chk("tbl_first_y", fy, tbl[i].fy);
        end

        // Reset in the middle of a fill: outputs clear at once, no done.
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 2'b00; bus.x0 = 8'd3; bus.y0 = 7'd4;
        bus.w = 7'd5; bus.h = 7'd5; bus.color_in = 3'd6;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_busy", {31'd0, bus.busy}, 32'd1);
        #2 resetn = 1'b0;
        #1 chk_zero("async_reset");
        @(negedge clk);
        resetn = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_seen++;
        end
        chk("no_done_after_reset", done_seen, 32'd0);
        run_cmd(0, 7, 9, 3, 3, 4, 1, cnt, runc, stalls, fx, fy);
        chk("after_reset_count", cnt, 32'd9);

        // Randomised commands against the model.
        for (int i = 0; i < 40; i++) begin
            run_cmd($urandom_range(0, 3), $urandom_range(0, XMOD - 1), $urandom_range(0, YMOD - 1),
                    $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 7), 1,
                    cnt, runc, stalls, fx, fy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
